// File: rtl/imem_fetch_ctrl.sv
// Program-memory sequencer: byte-serial loader writes words, fetch path reads
// them and presents instructions to decode through a valid/ready handshake.
module imem_fetch_ctrl #(
  parameter int             DEPTH       = 256,
  parameter int             WIDTH       = 32,
  parameter int             ADD_WIDTH   = 8,
  parameter logic [6:0]     HALT_OPCODE = 7'b1111111
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en,
  input  logic                 load_valid,
  input  logic [7:0]           load_byte,
  input  logic                 start,
  input  logic                 branch_valid,
  input  logic [ADD_WIDTH-1:0] branch_target,
  output logic [ADD_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 mem_we,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WIDTH-1:0]     instr,
  output logic [ADD_WIDTH-1:0] instr_pc,
  output logic                 halted,
  output logic                 busy
);

  localparam int BYTES = WIDTH / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0]        CNT_LAST  = CW'(BYTES - 1);
  localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
  localparam logic [ADD_WIDTH-1:0] ADDR_LAST = ADD_WIDTH'(DEPTH - 1);
  localparam logic [ADD_WIDTH-1:0] ADDR_ONE  = ADD_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  state_t               state, state_n;
  logic [ADD_WIDTH-1:0] pc, pc_n, pc_inc;
  logic [ADD_WIDTH-1:0] load_addr, load_addr_n, load_addr_inc;
  logic [CW-1:0]        byte_cnt, byte_cnt_n;
  logic [WIDTH-1:0]     word_buf, word_buf_n, word_ins;
  logic                 mem_we_n;
  logic [WIDTH-1:0]     mem_wdata_n;
  logic                 instr_valid_n;
  logic [WIDTH-1:0]     instr_n;
  logic [ADD_WIDTH-1:0] instr_pc_n;
  logic                 halted_n;

  // Wrap at DEPTH-1 rather than relying on natural overflow of the register.
  assign pc_inc        = (pc == ADDR_LAST) ? '0 : pc + ADDR_ONE;
  assign load_addr_inc = (load_addr == ADDR_LAST) ? '0 : load_addr + ADDR_ONE;

  always_comb begin
    word_ins = word_buf;
    for (int i = 0; i < BYTES; i++)
      if (byte_cnt == CW'(i)) word_ins[8*i +: 8] = load_byte;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    load_addr_n   = mem_we ? load_addr_inc : load_addr;
    byte_cnt_n    = byte_cnt;
    word_buf_n    = word_buf;
    mem_we_n      = 1'b0;
    mem_wdata_n   = mem_wdata;
    instr_valid_n = instr_ready ? 1'b0 : instr_valid;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    halted_n      = halted;

    unique case (state)
      IDLE: begin
        if (load_en) begin
          state_n     = LOAD;
          load_addr_n = '0;
          byte_cnt_n  = '0;
        end else if (start) begin
          state_n = RUN;
          pc_n    = '0;
        end
      end
      LOAD: begin
        if (!load_en) begin
          state_n    = IDLE;
          byte_cnt_n = '0;
        end else if (load_valid) begin
          word_buf_n = word_ins;
          byte_cnt_n = (byte_cnt == CNT_LAST) ? '0 : byte_cnt + CNT_ONE;
          if (byte_cnt == CNT_LAST) begin
            mem_we_n    = 1'b1;
            mem_wdata_n = word_ins;
          end
        end
      end
      RUN: begin
        if (load_en) begin
          state_n       = LOAD;
          instr_valid_n = 1'b0;
          load_addr_n   = '0;
          byte_cnt_n    = '0;
        end else if (branch_valid) begin
          instr_valid_n = 1'b0;
          pc_n          = branch_target;
        end else if (!instr_valid || instr_ready) begin
          instr_n       = mem_rdata;
          instr_pc_n    = pc;
          instr_valid_n = 1'b1;
          if (mem_rdata[6:0] == HALT_OPCODE) begin
            state_n  = HALT;
            halted_n = 1'b1;
          end else begin
            pc_n = pc_inc;
          end
        end
      end
      HALT: begin
        if (load_en) begin
          state_n       = LOAD;
          halted_n      = 1'b0;
          instr_valid_n = 1'b0;
          load_addr_n   = '0;
          byte_cnt_n    = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      load_addr   <= '0;
      byte_cnt    <= '0;
      word_buf    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      load_addr   <= load_addr_n;
      byte_cnt    <= byte_cnt_n;
      word_buf    <= word_buf_n;
      mem_we      <= mem_we_n;
      mem_wdata   <= mem_wdata_n;
      instr_valid <= instr_valid_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      halted      <= halted_n;
    end
  end

  assign mem_addr = mem_we ? load_addr : pc;
  assign busy     = (state == LOAD) || (state == RUN);

endmodule
